// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time a burst of up
// to BURST_LEN beats into a shared fifo, with one arbitration cycle between bursts.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_w_req,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_w_ready,
  input  logic                          fifo_amst_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   last_ptr, last_ptr_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [IDX_W-1:0]   sel;
  logic               sel_vld;
  logic               beat;

  // Scan from last_ptr+1 upward; iterating downward lets the nearest requester win.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last_ptr) + i) % NUM_REQ]) begin
        sel     = IDX_W'((int'(last_ptr) + i) % NUM_REQ);
        sel_vld = 1'b1;
      end
    end
  end

  assign beat            = (state == BURST) && req[gidx] && fifo_w_ready;
  assign fifo_w_req      = beat;
  assign ack             = beat ? grant : '0;
  assign busy            = (state == BURST);
  assign fifo_write_data = (state == BURST) ? wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    last_ptr_nxt = last_ptr;
    gidx_nxt     = gidx;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (sel_vld && !fifo_amst_full) begin
          state_nxt    = BURST;
          grant_nxt    = NUM_REQ'(1) << sel;
          last_ptr_nxt = sel;
          gidx_nxt     = sel;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        // A dropped request ends the burst; almost-full never interrupts it.
        if (!req[gidx]) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          beat_cnt_nxt = '0;
        end else if (beat) begin
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            state_nxt    = IDLE;
            grant_nxt    = '0;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      last_ptr <= IDX_W'(NUM_REQ - 1);
      gidx     <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      last_ptr <= last_ptr_nxt;
      gidx     <= gidx_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based producers feed the DUT and a scoreboard
// of expected fifo writes is checked on every write cycle.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  ack;
  logic          fifo_w_req;
  logic [DW-1:0] fifo_write_data;
  logic          fifo_w_ready;
  logic          fifo_amst_full;
  logic [N-1:0]  grant;
  logic          busy;

  logic [DW-1:0] pq [N][$];
  logic [N-1:0]  en;
  exp_t          exp_q [$];

  logic [N-1:0]  s_grant, s_ack;
  logic          s_busy, s_wreq;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack),
    .fifo_w_req(fifo_w_req), .fifo_write_data(fifo_write_data),
    .fifo_w_ready(fifo_w_ready), .fifo_amst_full(fifo_amst_full),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(int p, int k);
    return 8'(160 + p*16 + k);
  endfunction

  task automatic fill(int p, int n);
    for (int k = 0; k < n; k++) pq[p].push_back(dval(p, k));
  endtask

  task automatic push_exp(int p, int first, int n);
    exp_t e;
    for (int k = first; k < first + n; k++) begin
      e.ack  = N'(1) << p;
      e.data = dval(p, k);
      exp_q.push_back(e);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      req[i] = en[i] && (pq[i].size() != 0);
      wdata[i*DW +: DW] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
  endtask

  // One clock cycle: drive producers, sample at negedge, consume acked beats after the edge.
  task automatic step();
    exp_t e;
    refresh();
    @(negedge clk);
    s_grant = grant; s_busy = busy; s_wreq = fifo_w_req; s_ack = ack;
    checks++;
    if (((ack & (ack - 1'b1)) != 0) || ((ack & ~grant) != 0) || (fifo_w_req != (ack != 0))) begin
      errors++;
      $display("FAIL ack_invariant: ack=%b grant=%b w_req=%b", ack, grant, fifo_w_req);
    end
    if (fifo_w_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: ack=%b data=%h, required no write", ack, fifo_write_data);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e.ack || fifo_write_data !== e.data) begin
          errors++;
          $display("FAIL write: ack=%b data=%h, required ack=%b data=%h", ack, fifo_write_data, e.ack, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (s_ack[i] && pq[i].size() != 0) void'(pq[i].pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = '0; fifo_w_ready = 1'b1; fifo_amst_full = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    refresh();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_drained(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    en = 4'b0001;
    fill(0, 4);
    refresh();
    #1;
    checks++;
    if ({ack, fifo_w_req, fifo_write_data, grant, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b w_req=%b data=%h grant=%b busy=%b, required all 0",
               ack, fifo_w_req, fifo_write_data, grant, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    do_reset();
    en = 4'b0001;
    fill(0, 8);
    push_exp(0, 0, 8);
    for (int s = 0; s <= 10; s++) begin
      step();
      eg = ((s >= 1 && s <= 4) || (s >= 6 && s <= 9)) ? 4'b0001 : 4'b0000;
      checks++;
      if ({s_busy, s_grant} !== {|eg, eg}) begin
        errors++;
        $display("FAIL single_grant c%0d: busy=%b grant=%b, required busy=%b grant=%b", s, s_busy, s_grant, |eg, eg);
      end
    end
    check_drained("single");
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] eg;
    do_reset();
    en = 4'b1111;
    fill(0, 8); fill(1, 4); fill(2, 4); fill(3, 4);
    push_exp(0, 0, 4); push_exp(1, 0, 4); push_exp(2, 0, 4); push_exp(3, 0, 4); push_exp(0, 4, 4);
    for (int s = 0; s <= 25; s++) begin
      step();
      eg = (s % 5 == 0 || s == 25) ? 4'b0000 : N'(1) << order[s / 5];
      checks++;
      if (s_grant !== eg) begin
        errors++;
        $display("FAIL rr_grant c%0d: grant=%b, required %b", s, s_grant, eg);
      end
    end
    check_drained("rr");
  endtask

  task automatic test_backpressure();
    logic [7:0] wreq_t  = 8'b0111_0010;
    logic [7:0] grant_t = 8'b0111_1110;
    do_reset();
    en = 4'b0001;
    fill(0, 4);
    push_exp(0, 0, 4);
    for (int s = 0; s <= 7; s++) begin
      fifo_w_ready = !(s == 2 || s == 3);
      step();
      checks++;
      if (s_wreq !== wreq_t[s] || s_grant !== (grant_t[s] ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL backpressure c%0d: w_req=%b grant=%b, required w_req=%b grant=%b",
                 s, s_wreq, s_grant, wreq_t[s], grant_t[s] ? 4'b0001 : 4'b0000);
      end
    end
    fifo_w_ready = 1'b1;
    check_drained("backpressure");
  endtask

  task automatic test_almost_full();
    logic [N-1:0] eg;
    do_reset();
    en = 4'b0110;
    fill(1, 4); fill(2, 4);
    push_exp(1, 0, 4); push_exp(2, 0, 4);
    for (int s = 0; s <= 16; s++) begin
      fifo_amst_full = (s <= 3) || (s >= 6 && s <= 9);
      step();
      eg = (s >= 5 && s <= 8) ? 4'b0010 : (s >= 11 && s <= 14) ? 4'b0100 : 4'b0000;
      checks++;
      if ({s_busy, s_grant} !== {|eg, eg}) begin
        errors++;
        $display("FAIL amst_full c%0d: busy=%b grant=%b, required busy=%b grant=%b", s, s_busy, s_grant, |eg, eg);
      end
    end
    fifo_amst_full = 1'b0;
    check_drained("amst_full");
  endtask

  task automatic test_early_release();
    logic [N-1:0] eg;
    do_reset();
    en = 4'b1100;
    fill(2, 2); fill(3, 4);
    push_exp(2, 0, 2); push_exp(3, 0, 4);
    for (int s = 0; s <= 10; s++) begin
      step();
      eg = (s >= 1 && s <= 3) ? 4'b0100 : (s >= 5 && s <= 8) ? 4'b1000 : 4'b0000;
      checks++;
      if (s_grant !== eg || (s == 3 && s_wreq !== 1'b0)) begin
        errors++;
        $display("FAIL early_release c%0d: grant=%b w_req=%b, required grant=%b", s, s_grant, s_wreq, eg);
      end
    end
    check_drained("early_release");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    en = 4'b1001;
    fill(0, 4); fill(3, 4);
    push_exp(0, 0, 1);
    step();
    step();
    checks++;
    if (s_ack !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_pre: ack=%b, required 0001", s_ack);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ack, fifo_w_req, grant, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ack=%b w_req=%b grant=%b busy=%b, required all 0", ack, fifo_w_req, grant, busy);
    end
    step();
    reset = 1'b0;
    push_exp(0, 1, 3); push_exp(3, 0, 4);
    for (int s = 0; s <= 11; s++) begin
      step();
      if (s <= 1) begin
        checks++;
        if (s_grant !== (s == 1 ? 4'b0001 : 4'b0000)) begin
          errors++;
          $display("FAIL mid_reset_regrant c%0d: grant=%b, required %b", s, s_grant, s == 1 ? 4'b0001 : 4'b0000);
        end
      end
    end
    check_drained("mid_reset");
  endtask

  initial begin
    reset = 1'b1; en = '0; req = '0; wdata = '0;
    fifo_w_ready = 1'b1; fifo_amst_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_almost_full();
    test_early_release();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
